aurora_tx_write_packer: RTL and testbench



---
 rtl/aurora_pkg.sv | 47 ++++
 rtl/aurora_tx_write_packer.sv | 189 ++++++++++++++++++
 tb/tb_aurora_tx_write_packer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// -----------------------------------------------------------------------------
// aurora_pkg
// Shared definitions for the Aurora TX write packer.
//   - state_t          : packer FSM states (IDLE / SEND / RESP)
//   - packet field bit positions inside the 256-bit stream beat
//   - default write opcode and AXI BRESP codes
//   - pack_beat()      : assembles one stream beat from a captured AXI write
// -----------------------------------------------------------------------------
package aurora_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int PKT_W      = 256;
    localparam int WDATA_LSB  = 0;
    localparam int AWADDR_LSB = 32;
    localparam int WSTRB_LSB  = 64;
    localparam int SEQ_LSB    = 72;
    localparam int OPCODE_LSB = 88;

    localparam logic [7:0] OPCODE_WRITE_DEFAULT = 8'h01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Every bit not covered by a field is left at zero.
    function automatic logic [PKT_W-1:0] pack_beat(
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [3:0]  strb,
        input logic [7:0]  seq,
        input logic [7:0]  opcode
    );
        logic [PKT_W-1:0] beat;
        beat = '0;
        beat[WDATA_LSB  +: 32] = data;
        beat[AWADDR_LSB +: 32] = addr;
        beat[WSTRB_LSB  +: 4]  = strb;
        beat[SEQ_LSB    +: 8]  = seq;
        beat[OPCODE_LSB +: 8]  = opcode;
        return beat;
    endfunction

endpackage

// File: rtl/aurora_tx_write_packer.sv
// -----------------------------------------------------------------------------
// aurora_tx_write_packer
// Accepts AXI4-Lite writes and packs each into a single 256-bit, TLAST-marked
// stream beat for the Aurora USER_DATA_S_AXIS_TX port. The write response is
// returned only after the stream beat has been accepted downstream.
//
// Ports
//   user_clk, sys_reset          : clock, synchronous active-high reset
//   S_AXI_AW*                    : write address channel (slave)
//   S_AXI_W*                     : write data channel (slave)
//   S_AXI_B*                     : write response channel (slave)
//   AXIS_TX_*                    : 256-bit packet stream (master)
//
// Parameters
//   TIMEOUT_CYCLES : stream watchdog limit (only with TX_WATCHDOG_EN)
//   OPCODE_WRITE   : opcode placed in the packet header
//
// Configuration
//   TX_WATCHDOG_EN : when defined, a beat stalled by TREADY=0 for
//                    TIMEOUT_CYCLES cycles is dropped and answered with SLVERR.
// -----------------------------------------------------------------------------
module aurora_tx_write_packer
    import aurora_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] OPCODE_WRITE   = OPCODE_WRITE_DEFAULT
) (
    input  logic         user_clk,
    input  logic         sys_reset,

    input  logic [31:0]  S_AXI_AWADDR,
    input  logic         S_AXI_AWVALID,
    output logic         S_AXI_AWREADY,

    input  logic [31:0]  S_AXI_WDATA,
    input  logic [3:0]   S_AXI_WSTRB,
    input  logic         S_AXI_WVALID,
    output logic         S_AXI_WREADY,

    output logic [1:0]   S_AXI_BRESP,
    output logic         S_AXI_BVALID,
    input  logic         S_AXI_BREADY,

    output logic [255:0] AXIS_TX_TDATA,
    output logic         AXIS_TX_TVALID,
    output logic         AXIS_TX_TLAST,
    input  logic         AXIS_TX_TREADY
);

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_aw_held;
    logic         r_w_held;
    logic [31:0]  r_awaddr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wstrb;
    logic [7:0]   r_seq;
    logic [255:0] r_tdata;
    logic [1:0]   r_bresp;
    logic         r_awready;
    logic         r_wready;

    logic         w_aw_hs;
    logic         w_w_hs;
    logic         w_aw_held_nxt;
    logic         w_w_held_nxt;
    logic [31:0]  w_awaddr_nxt;
    logic [31:0]  w_wdata_nxt;
    logic [3:0]   w_wstrb_nxt;
    logic         w_stream_hs;
    logic         w_timeout;

    // The ready flags are registered and only ever high in IDLE, so a
    // handshake on either channel implies the FSM is in IDLE.
    assign w_aw_hs       = S_AXI_AWVALID & r_awready;
    assign w_w_hs        = S_AXI_WVALID  & r_wready;
    assign w_aw_held_nxt = r_aw_held | w_aw_hs;
    assign w_w_held_nxt  = r_w_held  | w_w_hs;

    // Forward a channel captured this very cycle so the beat can be built
    // on the same edge that completes the pair.
    assign w_awaddr_nxt  = w_aw_hs ? S_AXI_AWADDR : r_awaddr;
    assign w_wdata_nxt   = w_w_hs  ? S_AXI_WDATA  : r_wdata;
    assign w_wstrb_nxt   = w_w_hs  ? S_AXI_WSTRB  : r_wstrb;

    assign w_stream_hs   = (r_state == SEND) & AXIS_TX_TREADY;

`ifdef TX_WATCHDOG_EN
    localparam int         WD_W     = 21;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Held at zero outside SEND, so every SEND entry starts from zero.
    always_ff @(posedge user_clk) begin
        if (sys_reset || r_state != SEND) begin
            r_wd_cnt <= '0;
        end else if (!AXIS_TX_TREADY) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == SEND) & ~AXIS_TX_TREADY & (r_wd_cnt == WD_LIMIT);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_aw_held_nxt && w_w_held_nxt) w_state_nxt = SEND;
            SEND: if (w_stream_hs || w_timeout)      w_state_nxt = RESP;
            RESP: if (S_AXI_BREADY)                  w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        AXIS_TX_TVALID = (r_state == SEND);
        AXIS_TX_TLAST  = (r_state == SEND);
        S_AXI_BVALID   = (r_state == RESP);
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = r_bresp;
    assign AXIS_TX_TDATA = r_tdata;

    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_seq     <= '0;
            r_tdata   <= '0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end

            // The held flags only matter while collecting in IDLE; once the
            // pair is complete its contents live in r_tdata, so the flags
            // drop as soon as the FSM leaves IDLE.
            r_aw_held <= w_aw_held_nxt & (w_state_nxt == IDLE);
            r_w_held  <= w_w_held_nxt  & (w_state_nxt == IDLE);

            // Beat is frozen on entry to SEND, keeping TDATA stable under
            // backpressure.
            if (r_state == IDLE && w_state_nxt == SEND) begin
                r_tdata <= pack_beat(w_awaddr_nxt, w_wdata_nxt, w_wstrb_nxt,
                                     r_seq, OPCODE_WRITE);
            end

            if (w_stream_hs) begin
                r_seq   <= r_seq + 8'd1;
                r_bresp <= RESP_OKAY;
            end else if (w_timeout) begin
                r_bresp <= RESP_SLVERR;
            end

            // Registered readies: low during reset, high one edge after it,
            // and dropped on the edge that captures the channel.
            r_awready <= (w_state_nxt == IDLE) & ~w_aw_held_nxt;
            r_wready  <= (w_state_nxt == IDLE) & ~w_w_held_nxt;
        end
    end

endmodule

// File: tb/tb_aurora_tx_write_packer.sv
// -----------------------------------------------------------------------------
// tb_aurora_tx_write_packer
// Directed stimulus with a scoreboard: each issued write pushes its expected
// stream beat and write response; a monitor pops and compares on every
// stream / B handshake.
// -----------------------------------------------------------------------------
module tb_aurora_tx_write_packer;

    logic         user_clk = 1'b0;
    logic         sys_reset;
    logic [31:0]  S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [255:0] AXIS_TX_TDATA;
    logic         AXIS_TX_TVALID;
    logic         AXIS_TX_TLAST;
    logic         AXIS_TX_TREADY;

    aurora_tx_write_packer #(
        .TIMEOUT_CYCLES (16),
        .OPCODE_WRITE   (8'h01)
    ) dut (
        .user_clk       (user_clk),
        .sys_reset      (sys_reset),
        .S_AXI_AWADDR   (S_AXI_AWADDR),
        .S_AXI_AWVALID  (S_AXI_AWVALID),
        .S_AXI_AWREADY  (S_AXI_AWREADY),
        .S_AXI_WDATA    (S_AXI_WDATA),
        .S_AXI_WSTRB    (S_AXI_WSTRB),
        .S_AXI_WVALID   (S_AXI_WVALID),
        .S_AXI_WREADY   (S_AXI_WREADY),
        .S_AXI_BRESP    (S_AXI_BRESP),
        .S_AXI_BVALID   (S_AXI_BVALID),
        .S_AXI_BREADY   (S_AXI_BREADY),
        .AXIS_TX_TDATA  (AXIS_TX_TDATA),
        .AXIS_TX_TVALID (AXIS_TX_TVALID),
        .AXIS_TX_TLAST  (AXIS_TX_TLAST),
        .AXIS_TX_TREADY (AXIS_TX_TREADY)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [255:0] exp_beats[$];
    logic [1:0]   exp_resp[$];
    logic [7:0]   m_seq = 8'd0;
    logic [255:0] mon_beat;
    logic [1:0]   mon_resp;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference beat layout written out field by field, MSB first.
    function automatic logic [255:0] beat(input logic [31:0] addr, input logic [31:0] data,
                                          input logic [3:0] strb, input logic [7:0] seq);
        return {160'd0, 8'h01, 8'h00, seq, 4'h0, strb, addr, data};
    endfunction

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [255:0] b);
        b = beat(addr, data, strb, m_seq);
        exp_beats.push_back(b);
        exp_resp.push_back(2'b00);
        m_seq = m_seq + 8'd1;
    endtask

    task automatic drive_aw(input logic [31:0] addr);
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        while (!S_AXI_AWREADY && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        if (n >= 200) check("aw_wait_timeout", 1'b0, n, 200);
        @(posedge user_clk);
        #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        while (!S_AXI_WREADY && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        if (n >= 200) check("w_wait_timeout", 1'b0, n, 200);
        @(posedge user_clk);
        #1;
        S_AXI_WVALID = 1'b0;
    endtask

    // w_lead > 0: W issued w_lead cycles before AW; < 0: AW leads.
    task automatic write_pair(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int w_lead);
        fork
            begin
                if (w_lead > 0) begin repeat (w_lead) @(posedge user_clk); #1; end
                drive_aw(addr);
            end
            begin
                if (w_lead < 0) begin repeat (-w_lead) @(posedge user_clk); #1; end
                drive_w(data, strb);
            end
        join
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge user_clk);
            n++;
        end while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50);
        check(name, n < 50, n, 50);
    endtask

    // Scoreboard monitor
    always @(negedge user_clk) begin
        if (!sys_reset) begin
            if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", 1'b0, AXIS_TX_TDATA, 0);
                end else begin
                    mon_beat = exp_beats.pop_front();
                    check("beat_tdata", AXIS_TX_TDATA == mon_beat, AXIS_TX_TDATA, mon_beat);
                    check("beat_tlast", AXIS_TX_TLAST == 1'b1, AXIS_TX_TLAST, 1);
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_resp.size() == 0) begin
                    check("bresp_unexpected", 1'b0, S_AXI_BRESP, 0);
                end else begin
                    mon_resp = exp_resp.pop_front();
                    check("bresp", S_AXI_BRESP == mon_resp, S_AXI_BRESP, mon_resp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [255:0] b;
        int t0;
        int n;

        sys_reset      = 1'b1;
        S_AXI_AWADDR   = '0;
        S_AXI_AWVALID  = 1'b0;
        S_AXI_WDATA    = '0;
        S_AXI_WSTRB    = '0;
        S_AXI_WVALID   = 1'b0;
        S_AXI_BREADY   = 1'b1;
        AXIS_TX_TREADY = 1'b1;

        // Reset state
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        check("rst_tdata", AXIS_TX_TDATA == '0, AXIS_TX_TDATA, 0);
        check("rst_ctrl", {AXIS_TX_TVALID, AXIS_TX_TLAST, S_AXI_BVALID, S_AXI_AWREADY,
                           S_AXI_WREADY, S_AXI_BRESP} == 7'd0,
              {AXIS_TX_TVALID, AXIS_TX_TLAST, S_AXI_BVALID, S_AXI_AWREADY,
               S_AXI_WREADY, S_AXI_BRESP}, 0);
        @(posedge user_clk);
        #1 sys_reset = 1'b0;
        @(negedge user_clk);
        check("ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY} == 2'b00,
              {S_AXI_AWREADY, S_AXI_WREADY}, 0);
        @(negedge user_clk);
        check("ready_after_edge", {S_AXI_AWREADY, S_AXI_WREADY} == 2'b11,
              {S_AXI_AWREADY, S_AXI_WREADY}, 3);

        // Basic write, both channels together
        push_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, b);
        write_pair(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        check("basic_tvalid", AXIS_TX_TVALID == 1'b1, AXIS_TX_TVALID, 1);
        @(posedge user_clk);
        #1;
        check("basic_bvalid", S_AXI_BVALID == 1'b1 && S_AXI_BRESP == 2'b00,
              {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
        wait_idle("basic_idle");

        // Channel ordering: W first, then AW first
        push_write(32'h0000_0020, 32'h1111_2222, 4'h3, b);
        write_pair(32'h0000_0020, 32'h1111_2222, 4'h3, 3);
        check("wfirst_tvalid", AXIS_TX_TVALID == 1'b1, AXIS_TX_TVALID, 1);
        wait_idle("wfirst_idle");
        push_write(32'h0000_0030, 32'h3333_4444, 4'hC, b);
        write_pair(32'h0000_0030, 32'h3333_4444, 4'hC, -3);
        check("awfirst_tvalid", AXIS_TX_TVALID == 1'b1, AXIS_TX_TVALID, 1);
        wait_idle("awfirst_idle");

        // Backpressure for 20 cycles, with an all-zero strobe
        @(posedge user_clk);
        #1 AXIS_TX_TREADY = 1'b0;
        push_write(32'h0000_ABC0, 32'h0BAD_F00D, 4'h0, b);
        write_pair(32'h0000_ABC0, 32'h0BAD_F00D, 4'h0, 0);
        repeat (20) begin
            @(negedge user_clk);
            check("bp_hold", AXIS_TX_TVALID && AXIS_TX_TDATA == b && !S_AXI_BVALID &&
                             !S_AXI_AWREADY && !S_AXI_WREADY,
                  {AXIS_TX_TVALID, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, AXIS_TX_TDATA},
                  {4'b1000, b});
        end
        @(posedge user_clk);
        #1 AXIS_TX_TREADY = 1'b1;
        wait_idle("bp_idle");

        // Reset while a beat is held in SEND
        @(posedge user_clk);
        #1 AXIS_TX_TREADY = 1'b0;
        write_pair(32'h0000_0055, 32'h1234_5678, 4'hF, 0);
        @(negedge user_clk);
        check("rst_pre_tvalid", AXIS_TX_TVALID == 1'b1, AXIS_TX_TVALID, 1);
        @(posedge user_clk);
        #1 sys_reset = 1'b1;
        @(negedge user_clk);
        check("rst_mid_ready", {S_AXI_AWREADY, S_AXI_WREADY} == 2'b00,
              {S_AXI_AWREADY, S_AXI_WREADY}, 0);
        @(posedge user_clk);
        #1;
        check("rst_mid_out", !AXIS_TX_TVALID && !S_AXI_BVALID && AXIS_TX_TDATA == '0,
              {AXIS_TX_TVALID, S_AXI_BVALID, AXIS_TX_TDATA}, 0);
        sys_reset      = 1'b0;
        AXIS_TX_TREADY = 1'b1;
        m_seq          = 8'd0;
        repeat (3) @(negedge user_clk);
        check("rst_no_b", !S_AXI_BVALID && !AXIS_TX_TVALID,
              {S_AXI_BVALID, AXIS_TX_TVALID}, 0);
        wait_idle("rst_idle");
        push_write(32'h0000_0060, 32'hCAFE_0000, 4'h5, b);
        write_pair(32'h0000_0060, 32'hCAFE_0000, 4'h5, 0);
        wait_idle("rst_next_idle");

        // 257 back-to-back writes: sequence wraps, 3 cycles per write
        t0 = cyc;
        for (int i = 0; i < 257; i++) begin
            push_write(32'h1000_0000 + 32'(i * 4), 32'(i) ^ 32'hA5A5_0000, 4'hF, b);
            write_pair(32'h1000_0000 + 32'(i * 4), 32'(i) ^ 32'hA5A5_0000, 4'hF, 0);
        end
        check("throughput", (cyc - t0) <= 257 * 3 + 3, cyc - t0, 257 * 3 + 3);
        wait_idle("wrap_idle");

`ifdef TX_WATCHDOG_EN
        // Watchdog: beat dropped after 16 stalled cycles, SLVERR, seq unchanged
        @(posedge user_clk);
        #1 AXIS_TX_TREADY = 1'b0;
        exp_resp.push_back(2'b10);
        write_pair(32'h0000_0070, 32'h7777_7777, 4'hF, 0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge user_clk);
            if (!AXIS_TX_TVALID) break;
            n++;
        end
        check("wd_tvalid_cycles", n == 16, n, 16);
        @(posedge user_clk);
        #1 AXIS_TX_TREADY = 1'b1;
        wait_idle("wd_idle");
        push_write(32'h0000_0080, 32'h8888_8888, 4'hF, b);
        write_pair(32'h0000_0080, 32'h8888_8888, 4'hF, 0);
        wait_idle("wd_next_idle");
`endif

        repeat (5) @(negedge user_clk);
        check("beats_drained", exp_beats.size() == 0, exp_beats.size(), 0);
        check("resps_drained", exp_resp.size() == 0, exp_resp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
